// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin at a time, largest first, through a two-tube hopper.
module change_dispenser #(
  parameter int COIN_HI = 5,
  parameter int TIMEOUT_CYC = 255,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] vuelto,
  input  logic         hopperAck,
  input  logic         empty500,
  input  logic         empty100,
  input  logic         clearFault,
  output logic         eject500,
  output logic         eject100,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [W-1:0] owed
);
  typedef enum logic [2:0] {IDLE, LOAD, SELECT, WAIT_ACK, DONE, FAULT} state_t;
  state_t state, nxt;
  logic enable_q, ack_q, hi_q, start, pick_hi, pick_lo;
  logic [W-1:0] timer;
  assign start = enable & ~enable_q;
  assign pick_hi = owed >= W'(COIN_HI) && !empty500;
  assign pick_lo = owed != '0 && !empty100;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? LOAD : IDLE;
      LOAD:     nxt = SELECT;
      SELECT:   nxt = owed == '0 ? DONE : (pick_hi || pick_lo) ? WAIT_ACK : FAULT;
      WAIT_ACK: nxt = ack_q ? SELECT : (!hopperAck && timer == W'(TIMEOUT_CYC)) ? FAULT : WAIT_ACK;
      DONE:     nxt = IDLE;
      FAULT:    nxt = clearFault ? IDLE : FAULT;
      default:  nxt = IDLE;
    endcase
  end
  // the ack is held for one cycle so the owed update settles before the next selection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      enable_q <= 1'b0;
      ack_q <= 1'b0;
      hi_q <= 1'b0;
      timer <= '0;
      owed <= '0;
      eject500 <= 1'b0;
      eject100 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      enable_q <= enable;
      ack_q <= state == WAIT_ACK && hopperAck && !ack_q;
      eject500 <= state == SELECT && nxt == WAIT_ACK && pick_hi;
      eject100 <= state == SELECT && nxt == WAIT_ACK && !pick_hi;
      done <= state == DONE;
      fault <= nxt == FAULT;
      busy <= nxt != IDLE && nxt != FAULT;
      timer <= (state == WAIT_ACK && !ack_q) ? timer + W'(1) : '0;
      if (state == SELECT) hi_q <= pick_hi;
      if (state == IDLE && start) owed <= vuelto;
      else if (state == WAIT_ACK && ack_q) owed <= owed - (hi_q ? W'(COIN_HI) : W'(1));
      else if (state == FAULT && clearFault) owed <= '0;
    end
  end
endmodule
